// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_if
// Brief    : Fetch-stage bundle: redirect input, instruction bus, if_id handshake.
// Revision : 1.0
// ============================================================================
interface if_fetch_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;

    modport master (
        input  jump_en_i, jump_addr_i, ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i, inst_ready_i,
        output ibus_req_o, ibus_addr_o, inst_valid_o, inst_addr_o, inst_o
    );

    modport slave (
        output jump_en_i, jump_addr_i, ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i, inst_ready_i,
        input  ibus_req_o, ibus_addr_o, inst_valid_o, inst_addr_o, inst_o
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : PC owner, pipelined ibus requester and fetch buffer for if_id.
//            Optional same-cycle response bypass: IF_FETCH_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);
    localparam int         PW        = $clog2(FIFO_DEPTH);
    localparam int         CW        = PW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;

    logic [31:0]   aq_mem [FIFO_DEPTH];
    logic [PW-1:0] aq_wr;
    logic [PW-1:0] aq_rd;

    logic [31:0]   fa_mem [FIFO_DEPTH];
    logic [31:0]   fd_mem [FIFO_DEPTH];
    logic [PW-1:0] f_wr;
    logic [PW-1:0] f_rd;

    logic [CW:0]   credit_sum;
    logic          req;
    logic          grant;
    logic          resp;
    logic          drop;
    logic          keep;
    logic          head_valid;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] count_next;

    // Credit uses registered occupancy only; a same-cycle pop does not free a slot.
    always_comb begin
        credit_sum = {1'b0, inflight} + {1'b0, count};
        req        = !rst && !bus.jump_en_i && (credit_sum < DEPTH_LIM);
    end

    assign grant      = req && bus.ibus_gnt_i;
    assign resp       = bus.ibus_rvalid_i && (inflight != '0);
    assign drop       = resp && (bus.jump_en_i || (discard != '0));
    assign keep       = resp && !drop;
    assign head_valid = (count != '0);

`ifdef IF_FETCH_BYPASS_EN
    assign bypass = keep && !head_valid;
`else
    assign bypass = 1'b0;
`endif

    assign pop           = head_valid && bus.inst_ready_i && !bus.jump_en_i;
    assign push          = keep && !(bypass && bus.inst_ready_i);
    assign inflight_next = inflight + CW'(grant) - CW'(resp);
    assign count_next    = bus.jump_en_i ? '0 : (count + CW'(push) - CW'(pop));

    assign bus.ibus_req_o  = req;
    assign bus.ibus_addr_o = pc;

    always_comb begin
        bus.inst_valid_o = head_valid;
        bus.inst_addr_o  = head_valid ? fa_mem[f_rd] : 32'h0000_0000;
        bus.inst_o       = head_valid ? fd_mem[f_rd] : NOP_INST;
`ifdef IF_FETCH_BYPASS_EN
        if (bypass) begin
            bus.inst_valid_o = 1'b1;
            bus.inst_addr_o  = aq_mem[aq_rd];
            bus.inst_o       = bus.ibus_rdata_i;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_ADDR;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            aq_wr    <= '0;
            aq_rd    <= '0;
            f_wr     <= '0;
            f_rd     <= '0;
        end else begin
            inflight <= inflight_next;
            count    <= count_next;

            if (bus.jump_en_i) begin
                pc <= bus.jump_addr_i & ~32'h0000_0003;
            end else if (grant) begin
                pc <= pc + 32'd4;
            end

            if (grant) begin
                aq_wr <= aq_wr + PW'(1);
            end
            if (resp) begin
                aq_rd <= aq_rd + PW'(1);
            end

            // Everything still outstanding after a redirect belongs to the old stream.
            if (bus.jump_en_i) begin
                discard <= inflight_next;
            end else if (resp && (discard != '0)) begin
                discard <= discard - CW'(1);
            end

            if (bus.jump_en_i) begin
                f_wr <= '0;
                f_rd <= '0;
            end else begin
                if (push) begin
                    f_wr <= f_wr + PW'(1);
                end
                if (pop) begin
                    f_rd <= f_rd + PW'(1);
                end
            end
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (grant) begin
            aq_mem[aq_wr] <= pc;
        end
        if (push) begin
            fa_mem[f_wr] <= aq_mem[aq_rd];
            fd_mem[f_wr] <= bus.ibus_rdata_i;
        end
    end
endmodule
`default_nettype wire
